queue_ctrl: RTL and testbench

QUEUE_CTRL -- requirements
Module: queue_ctrl

---
 rtl/queue_ctrl_pkg.sv | 15 +
 rtl/queue_ctrl_edge_det.sv | 40 ++++
 rtl/queue_ctrl.sv | 110 +++++++++++
 tb/tb_queue_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/queue_ctrl_pkg.sv
// Shared widths, limits and FSM state encoding for the queue occupancy controller.
package queue_ctrl_pkg;

    localparam int PCOUNT_W   = 3;
    localparam int TCOUNT_W   = 2;
    localparam int PCOUNT_MAX = 7;
    localparam int INDEX_W    = 5;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } queue_state_t;

endpackage

// File: rtl/queue_ctrl_edge_det.sv
// Rising-edge detector for one photocell; QUEUE_SYNC_EN adds a two-flop synchronizer
// in front of the edge detection.
module queue_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sensor,
    output logic rise
);

    logic sensor_s;
    logic prev_reg;

`ifdef QUEUE_SYNC_EN
    logic sync1_reg;
    logic sync2_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= sensor;
            sync2_reg <= sync1_reg;
        end
    end

    assign sensor_s = sync2_reg;
`else
    assign sensor_s = sensor;
`endif

    // The previous sample keeps tracking during reset so a sensor already high
    // at release is not mistaken for a new arrival.
    always_ff @(posedge clk) begin
        prev_reg <= sensor_s;
    end

    assign rise = sensor_s & ~prev_reg;

endmodule

// File: rtl/queue_ctrl.sv
// Queue occupancy controller: counts people between entry/exit photocells and
// builds the wait-time ROM index. Define QUEUE_SYNC_EN to synchronize the sensors.
module queue_ctrl
    import queue_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                enter_s,
    input  logic                exit_s,
    input  logic [TCOUNT_W-1:0] tcount,
    output logic [PCOUNT_W-1:0] pcount,
    output logic                ef,
    output logic                ff,
    output logic [INDEX_W-1:0]  index,
    output logic                ovf,
    output logic                udf
);

    localparam logic [PCOUNT_W-1:0] PCOUNT_FULL = PCOUNT_W'(PCOUNT_MAX);
    localparam logic [PCOUNT_W-1:0] PCOUNT_ONE  = PCOUNT_W'(1);

    logic enter_ev;
    logic exit_ev;

    queue_edge_det u_enter_det (
        .clk   (clk),
        .reset (reset),
        .sensor(enter_s),
        .rise  (enter_ev)
    );

    queue_edge_det u_exit_det (
        .clk   (clk),
        .reset (reset),
        .sensor(exit_s),
        .rise  (exit_ev)
    );

    queue_state_t          state_reg, state_next;
    logic [PCOUNT_W-1:0]   pcount_reg, pcount_next;
    logic [TCOUNT_W-1:0]   tcount_q_reg;
    logic                  ef_reg, ff_reg, ovf_reg, ovf_next, udf_reg, udf_next;

    // Simultaneous entry and exit cancel, so only lone events move the count.
    always_comb begin
        state_next  = state_reg;
        pcount_next = pcount_reg;
        ovf_next    = 1'b0;
        udf_next    = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (enter_ev && !exit_ev) begin
                    pcount_next = pcount_reg + PCOUNT_ONE;
                    state_next  = ACTIVE;
                end else if (exit_ev && !enter_ev) begin
                    udf_next = 1'b1;
                end
            end
            ACTIVE: begin
                if (enter_ev && !exit_ev) begin
                    pcount_next = pcount_reg + PCOUNT_ONE;
                    if (pcount_next == PCOUNT_FULL) state_next = FULL;
                end else if (exit_ev && !enter_ev) begin
                    pcount_next = pcount_reg - PCOUNT_ONE;
                    if (pcount_next == '0) state_next = EMPTY;
                end
            end
            FULL: begin
                if (enter_ev && !exit_ev) begin
                    ovf_next = 1'b1;
                end else if (exit_ev && !enter_ev) begin
                    pcount_next = pcount_reg - PCOUNT_ONE;
                    state_next  = ACTIVE;
                end
            end
            default: begin
                state_next  = EMPTY;
                pcount_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= EMPTY;
            pcount_reg   <= '0;
            ef_reg       <= 1'b1;
            ff_reg       <= 1'b0;
            ovf_reg      <= 1'b0;
            udf_reg      <= 1'b0;
            tcount_q_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pcount_reg   <= pcount_next;
            ef_reg       <= (state_next == EMPTY);
            ff_reg       <= (state_next == FULL);
            ovf_reg      <= ovf_next;
            udf_reg      <= udf_next;
            tcount_q_reg <= tcount;
        end
    end

    assign pcount = pcount_reg;
    assign ef     = ef_reg;
    assign ff     = ff_reg;
    assign ovf    = ovf_reg;
    assign udf    = udf_reg;
    assign index  = {tcount_q_reg, pcount_reg};

endmodule

// File: tb/tb_queue_ctrl.sv
// Self-checking bench for queue_ctrl: directed scenarios followed by random traffic,
// compared every cycle against an occupancy-count model.
module tb_queue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enter_s;
    logic       exit_s;
    logic [1:0] tcount;
    logic [2:0] pcount;
    logic       ef, ff, ovf, udf;
    logic [4:0] index;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: people in queue plus last seen sensor levels.
    int  m_count;
    int  m_tq;
    bit  m_prev_e, m_prev_x;
    bit  m_ovf, m_udf;
    int  ovf_seen, udf_seen;

    queue_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .enter_s(enter_s),
        .exit_s (exit_s),
        .tcount (tcount),
        .pcount (pcount),
        .ef     (ef),
        .ff     (ff),
        .index  (index),
        .ovf    (ovf),
        .udf    (udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, compare all outputs.
    task automatic step(input bit e, input bit x, input bit [1:0] t, input bit rst);
        bit ev_e, ev_x;
        reset   = rst;
        enter_s = e;
        exit_s  = x;
        tcount  = t;
        @(posedge clk);
        ev_e = e && !m_prev_e;
        ev_x = x && !m_prev_x;
        m_prev_e = e;
        m_prev_x = x;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        if (rst) begin
            m_count = 0;
            m_tq    = 0;
        end else begin
            m_tq = t;
            if (ev_e && !ev_x) begin
                if (m_count == 7) m_ovf = 1'b1;
                else              m_count = m_count + 1;
            end else if (ev_x && !ev_e) begin
                if (m_count == 0) m_udf = 1'b1;
                else              m_count = m_count - 1;
            end
        end
        #1;
        ovf_seen += int'(ovf === 1'b1);
        udf_seen += int'(udf === 1'b1);
        $display("[TB] t=%0t rst=%0b en=%0b ex=%0b tc=%0d -> pcount=%0d ef=%0b ff=%0b ovf=%0b udf=%0b index=%b",
                 $time, rst, e, x, t, pcount, ef, ff, ovf, udf, index);
        check("pcount", 8'(pcount), 8'(m_count));
        check("ef",     8'(ef),     8'(m_count == 0));
        check("ff",     8'(ff),     8'(m_count == 7));
        check("ovf",    8'(ovf),    8'(m_ovf));
        check("udf",    8'(udf),    8'(m_udf));
        check("index",  8'(index),  8'((m_tq << 3) | m_count));
    endtask

    task automatic pulse_enter(input int width);
        for (int i = 0; i < width; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    initial begin
        m_count = 0; m_tq = 0; m_prev_e = 0; m_prev_x = 0;
        ovf_seen = 0; udf_seen = 0;

        // Reset, then three 4-cycle-wide entry pulses
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        for (int p = 0; p < 3; p++) pulse_enter(4);
        check("dir_three_entries", 8'(pcount), 8'd3);

        // Eight entries from empty: full after seven, one overflow on the eighth
        step(0, 0, 0, 1);
        ovf_seen = 0;
        for (int p = 0; p < 7; p++) pulse_enter(1);
        check("dir_full_flag", 8'(ff), 8'd1);
        pulse_enter(2);
        check("dir_ovf_once", 8'(ovf_seen), 8'd1);
        check("dir_stays_7", 8'(pcount), 8'd7);

        // Simultaneous rise while full: net zero
        ovf_seen = 0; udf_seen = 0;
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        check("dir_both_full", 8'(pcount), 8'd7);
        check("dir_both_full_pulses", 8'(ovf_seen + udf_seen), 8'd0);

        // Exit while empty: one underflow
        step(0, 0, 0, 1);
        udf_seen = 0;
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("dir_udf_once", 8'(udf_seen), 8'd1);
        check("dir_empty_flag", 8'(ef), 8'd1);

        // Simultaneous rise while empty: net zero
        ovf_seen = 0; udf_seen = 0;
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        check("dir_both_empty", 8'(pcount), 8'd0);
        check("dir_both_empty_pulses", 8'(ovf_seen + udf_seen), 8'd0);

        // tcount=2 with five people
        for (int p = 0; p < 5; p++) pulse_enter(1);
        step(0, 0, 2, 0);
        check("dir_index_10101", 8'(index), 8'b0001_0101);

        // Reset at four people discards the count
        step(0, 1, 2, 0);
        step(0, 0, 2, 0);
        step(0, 0, 2, 1);
        check("dir_reset_mid", 8'(pcount), 8'd0);
        check("dir_reset_ef", 8'(ef), 8'd1);

        // Entry sensor held across reset release: no event
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("dir_held_across_reset", 8'(pcount), 8'd0);

        // Random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)), $urandom_range(0, 60) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
